rvx_bus_arbiter: RTL and testbench
==================================

RVX_BUS_ARBITER -- requirements
Module: rvx_bus_arbiter

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: response-wait limit in cycles; 0 disables timeout.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width of all ports.
- REQ-003 SHALL have port clock  in  1: single clock; everything is on its rising edge.
- REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
- REQ-005 SHALL have core instruction-side ports: ibus_address in 32; ibus_rrequest in 1; ibus_rdata out 32; ibus_rresponse out 1.
- REQ-006 SHALL have core data-side ports: dbus_address in 32; dbus_rrequest in 1; dbus_wrequest in 1; dbus_wdata in 32; dbus_wstrobe in 4; dbus_rdata out 32; dbus_rresponse out 1; dbus_wresponse out 1.
- REQ-007 SHALL have shared-memory ports: mem_address out 32; mem_rrequest out 1; mem_wrequest out 1; mem_wdata out 32; mem_wstrobe out 4; mem_rdata in 32; mem_rresponse in 1; mem_wresponse in 1.
- REQ-008 SHALL have port bus_timeout  out  1: one-cycle pulse when a transaction times out.

Function
- REQ-009 SHALL treat every request and response as a single-cycle pulse, with address, data and strobe valid in the request cycle.
- REQ-010 SHALL capture each port's request (type, address, wdata, wstrobe) into a per-port pending slot on its pulse; at most one pending per port.
- REQ-011 SHALL implement states IDLE, BUSY_I and BUSY_D.
- REQ-012 In IDLE, SHALL issue the winning request on mem_* in the same cycle it arrives or is pending, with zero added latency, then enter BUSY_I or BUSY_D.
- REQ-013 SHALL resolve simultaneous candidates as dbus over ibus, except as modified by REQ-026.
- REQ-014 In BUSY_x, SHALL hold all mem_*request low and forward the memory response pulse to the owner in the same cycle.
- REQ-015 SHALL drive owner rdata = mem_rdata in the response cycle.
- REQ-016 On a response, SHALL clear the owner's pending slot and return to IDLE.
- REQ-017 A request still pending SHALL issue in the cycle after the response; no back-to-back issue in the response cycle.
- REQ-018 SHALL pass a dbus pulse with both rrequest and wrequest set as a write only.
- REQ-019 SHALL ignore a response whose type mismatches the issued type, and SHALL ignore any response in IDLE.
- REQ-020 SHALL ignore a new request pulse on a port whose slot is already full (protocol violation; assertion in sim).
- REQ-021 SHALL keep an 8+ bit wait counter per transaction, cleared on issue and incremented each BUSY cycle.
- REQ-022 When the wait counter equals TIMEOUT_CYCLES (nonzero), SHALL pulse the owner's matching response with rdata 32'h0, pulse bus_timeout, and return to IDLE.
- REQ-023 After a timeout, SHALL discard a late memory response arriving in the following IDLE (REQ-019).

Reset
- REQ-024 On reset_n low, SHALL asynchronously force IDLE, clear both pending slots and the wait counter, and drive all *request, *response, bus_timeout and rdata outputs to 0.
- REQ-025 Reset mid-transaction SHALL drop the transaction silently; a response arriving after release SHALL be ignored.

Configuration
- REQ-026 Macro RVX_ARB_ROUND_ROBIN_EN, when defined: on simultaneous candidates, grant the port not granted last (1-bit last-grant register, reset to ibus, so the first contested grant goes to dbus).
- REQ-027 Without RVX_ARB_ROUND_ROBIN_EN: fixed dbus priority and no last-grant register.

Structure
- REQ-028 Package rvx_bus_arbiter_pkg SHALL hold the state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2) and the request-type constants (READ, WRITE).
- REQ-029 SHALL contain one sub-module, rvx_bus_arbiter_slot: the per-port pending register with capture and clear, instantiated twice.

Verification
- REQ-030 ibus read to 0x100 in idle -> mem_rrequest the same cycle with address 0x100; mem_rresponse 2 cycles later with 0xDEADBEEF -> ibus_rresponse with rdata 0xDEADBEEF.
- REQ-031 ibus and dbus reads in the same cycle (fixed priority) -> dbus issued first; ibus issued the cycle after the dbus response.
- REQ-032 With RVX_ARB_ROUND_ROBIN_EN, three contested pairs -> grants in the order dbus, ibus, dbus.
- REQ-033 dbus write 0x12345678, strobe 4'b0011 to 0x2000 -> mem_wrequest carries the exact data and strobe; mem_wresponse -> dbus_wresponse only.
- REQ-034 TIMEOUT_CYCLES=4, no response -> dbus_rresponse and bus_timeout in the 4th BUSY cycle with rdata 0; a later mem_rresponse is ignored.
- REQ-035 reset_n low while in BUSY_I -> outputs 0 immediately; after release, a stale mem_rresponse produces no ibus_rresponse.

Source files
------------

// File: rtl/rvx_bus_arbiter_pkg.sv
// Shared types for the two-master (ibus/dbus) to single-memory bus arbiter.
package rvx_bus_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/rvx_bus_arbiter_slot.sv
// One-deep pending-request slot for a bus master.
// The slot presents either its stored request or the live request.
module rvx_bus_arbiter_slot
  import rvx_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_i,
  input  req_type_e             type_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic                  clr_i,
  output logic                  vld_o,
  output req_type_e             type_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [STRB_W-1:0]     wstrb_o
);

  logic                  full_q, full_d;
  req_type_e             type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  cap;

  // A slot being cleared this cycle may take a new request in the same cycle.
  always_comb begin
    cap     = req_i && (!full_q || clr_i);
    full_d  = full_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (clr_i) full_d = 1'b0;
    if (cap) begin
      full_d  = 1'b1;
      type_d  = type_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
      wstrb_d = wstrb_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      type_q <= READ;
    end else begin
      full_q <= full_d;
      type_q <= type_d;
    end
  end

  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  assign vld_o   = full_q || req_i;
  assign type_o  = full_q ? type_q  : type_i;
  assign addr_o  = full_q ? addr_q  : addr_i;
  assign wdata_o = full_q ? wdata_q : wdata_i;
  assign wstrb_o = full_q ? wstrb_q : wstrb_i;

  assert property (@(posedge clock) disable iff (!reset_n)
                   !(req_i && full_q && !clr_i));

endmodule

// File: rtl/rvx_bus_arbiter.sv
// Arbitrates core ibus/dbus single-pulse requests onto one memory port.
// Define RVX_ARB_ROUND_ROBIN_EN for alternating grants on contention.
module rvx_bus_arbiter
  import rvx_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] ibus_address,
  input  logic                  ibus_rrequest,
  output logic [DATA_W-1:0]     ibus_rdata,
  output logic                  ibus_rresponse,
  input  logic [ADDR_WIDTH-1:0] dbus_address,
  input  logic                  dbus_rrequest,
  input  logic                  dbus_wrequest,
  input  logic [DATA_W-1:0]     dbus_wdata,
  input  logic [STRB_W-1:0]     dbus_wstrobe,
  output logic [DATA_W-1:0]     dbus_rdata,
  output logic                  dbus_rresponse,
  output logic                  dbus_wresponse,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rrequest,
  output logic                  mem_wrequest,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [STRB_W-1:0]     mem_wstrobe,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rresponse,
  input  logic                  mem_wresponse,
  output logic                  bus_timeout
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WAIT_W-1:0] TMO_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  arb_state_e            state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d, wait_nxt;

  logic                  i_vld, d_vld, i_clr, d_clr;
  req_type_e             i_type, d_type, sel_type, own_type;
  logic [ADDR_WIDTH-1:0] i_addr, d_addr;
  logic [DATA_W-1:0]     i_wdata, d_wdata, rsp_data;
  logic [STRB_W-1:0]     i_wstrb, d_wstrb;
  logic                  grant, rsp_hit, tmo;

`ifdef RVX_ARB_ROUND_ROBIN_EN
  logic                  last_q, last_d;
`endif

  rvx_bus_arbiter_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_i (
    .clock   (clock),
    .reset_n (reset_n),
    .req_i   (ibus_rrequest),
    .type_i  (READ),
    .addr_i  (ibus_address),
    .wdata_i ('0),
    .wstrb_i ('0),
    .clr_i   (i_clr),
    .vld_o   (i_vld),
    .type_o  (i_type),
    .addr_o  (i_addr),
    .wdata_o (i_wdata),
    .wstrb_o (i_wstrb)
  );

  // A pulse with both strobes set is carried as a write.
  rvx_bus_arbiter_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_d (
    .clock   (clock),
    .reset_n (reset_n),
    .req_i   (dbus_rrequest || dbus_wrequest),
    .type_i  (dbus_wrequest ? WRITE : READ),
    .addr_i  (dbus_address),
    .wdata_i (dbus_wdata),
    .wstrb_i (dbus_wstrobe),
    .clr_i   (d_clr),
    .vld_o   (d_vld),
    .type_o  (d_type),
    .addr_o  (d_addr),
    .wdata_o (d_wdata),
    .wstrb_o (d_wstrb)
  );

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    wait_nxt       = wait_q + 1'b1;
    grant          = GRANT_D;
    sel_type       = READ;
    own_type       = READ;
    rsp_hit        = 1'b0;
    tmo            = 1'b0;
    rsp_data       = '0;
    i_clr          = 1'b0;
    d_clr          = 1'b0;
    mem_address    = '0;
    mem_rrequest   = 1'b0;
    mem_wrequest   = 1'b0;
    mem_wdata      = '0;
    mem_wstrobe    = '0;
    ibus_rresponse = 1'b0;
    ibus_rdata     = '0;
    dbus_rresponse = 1'b0;
    dbus_wresponse = 1'b0;
    dbus_rdata     = '0;
    bus_timeout    = 1'b0;
`ifdef RVX_ARB_ROUND_ROBIN_EN
    last_d         = last_q;
`endif
    // Outputs are gated so reset forces them low even with live inputs.
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (i_vld || d_vld) begin
            grant = d_vld ? GRANT_D : GRANT_I;
`ifdef RVX_ARB_ROUND_ROBIN_EN
            if (i_vld && d_vld) grant = ~last_q;
            last_d = grant;
`endif
            if (grant == GRANT_D) begin
              sel_type    = d_type;
              mem_address = d_addr;
              mem_wdata   = d_wdata;
              mem_wstrobe = d_wstrb;
            end else begin
              sel_type    = i_type;
              mem_address = i_addr;
              mem_wdata   = i_wdata;
              mem_wstrobe = i_wstrb;
            end
            mem_rrequest = (sel_type == READ);
            mem_wrequest = (sel_type == WRITE);
            wait_d       = '0;
            state_d      = (grant == GRANT_D) ? BUSY_D : BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          own_type = (state_q == BUSY_D) ? d_type : i_type;
          rsp_hit  = (own_type == READ) ? mem_rresponse : mem_wresponse;
          tmo      = (TIMEOUT_CYCLES != 0) && !rsp_hit && (wait_nxt == TMO_LIMIT);
          wait_d   = wait_nxt;
          if (rsp_hit || tmo) begin
            state_d     = IDLE;
            rsp_data    = rsp_hit ? mem_rdata : '0;
            bus_timeout = tmo;
            if (state_q == BUSY_I) begin
              ibus_rresponse = 1'b1;
              ibus_rdata     = rsp_data;
              i_clr          = 1'b1;
            end else begin
              d_clr = 1'b1;
              if (own_type == READ) begin
                dbus_rresponse = 1'b1;
                dbus_rdata     = rsp_data;
              end else begin
                dbus_wresponse = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

`ifdef RVX_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_q <= GRANT_I;
    else          last_q <= last_d;
  end
`endif

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Directed table-driven bench for rvx_bus_arbiter (TIMEOUT_CYCLES = 4).
module tb_rvx_bus_arbiter;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] ibus_address, ibus_rdata;
  logic        ibus_rrequest, ibus_rresponse;
  logic [31:0] dbus_address, dbus_wdata, dbus_rdata;
  logic        dbus_rrequest, dbus_wrequest, dbus_rresponse, dbus_wresponse;
  logic [3:0]  dbus_wstrobe, mem_wstrobe;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_rrequest, mem_wrequest, mem_rresponse, mem_wresponse;
  logic        bus_timeout;

  int n_tests;
  int n_fail;

  always #5 clock = ~clock;

  rvx_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ibus_address   (ibus_address),
    .ibus_rrequest  (ibus_rrequest),
    .ibus_rdata     (ibus_rdata),
    .ibus_rresponse (ibus_rresponse),
    .dbus_address   (dbus_address),
    .dbus_rrequest  (dbus_rrequest),
    .dbus_wrequest  (dbus_wrequest),
    .dbus_wdata     (dbus_wdata),
    .dbus_wstrobe   (dbus_wstrobe),
    .dbus_rdata     (dbus_rdata),
    .dbus_rresponse (dbus_rresponse),
    .dbus_wresponse (dbus_wresponse),
    .mem_address    (mem_address),
    .mem_rrequest   (mem_rrequest),
    .mem_wrequest   (mem_wrequest),
    .mem_wdata      (mem_wdata),
    .mem_wstrobe    (mem_wstrobe),
    .mem_rdata      (mem_rdata),
    .mem_rresponse  (mem_rresponse),
    .mem_wresponse  (mem_wresponse),
    .bus_timeout    (bus_timeout)
  );

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic        dw;  logic [31:0] da; logic [31:0] dwd; logic [3:0] ds;
    logic        mrr; logic        mwr; logic [31:0] md;
    logic        er;  logic        ew;  logic [31:0] ea; logic [31:0] ewd; logic [3:0] es;
    logic        eir; logic        edr; logic        edw; logic [31:0] erd; logic et;
  } vec_t;

  vec_t tbl[$];
  vec_t rr_tbl[$];

  function automatic vec_t mk(
    input logic [31:0] ir, ia, dr, dw, da, dwd, ds, mrr, mwr, md,
    input logic [31:0] er, ew, ea, ewd, es, eir, edr, edw, erd, et);
    vec_t v;
    v.ir = ir[0];  v.ia = ia;
    v.dr = dr[0];  v.dw = dw[0];  v.da = da;  v.dwd = dwd; v.ds = ds[3:0];
    v.mrr = mrr[0]; v.mwr = mwr[0]; v.md = md;
    v.er = er[0];  v.ew = ew[0];  v.ea = ea;  v.ewd = ewd; v.es = es[3:0];
    v.eir = eir[0]; v.edr = edr[0]; v.edw = edw[0]; v.erd = erd; v.et = et[0];
    return v;
  endfunction

  function automatic vec_t idle_row();
    return mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0);
  endfunction

  function automatic vec_t wait_row(input logic [31:0] md);
    return mk(0,0, 0,0,0,0,0, 0,0,md, 0,0,0,0,0, 0,0,0,0,0);
  endfunction

  task automatic idle_inputs();
    ibus_rrequest = 1'b0; ibus_address = '0;
    dbus_rrequest = 1'b0; dbus_wrequest = 1'b0;
    dbus_address  = '0;   dbus_wdata    = '0; dbus_wstrobe = '0;
    mem_rresponse = 1'b0; mem_wresponse = 1'b0; mem_rdata = '0;
  endtask

  task automatic check(input string tag, input int idx,
                       input logic [137:0] exp, input logic [137:0] mask);
    logic [137:0] got;
    got = {mem_rrequest, mem_wrequest, mem_address, mem_wdata, mem_wstrobe,
           ibus_rresponse, ibus_rdata, dbus_rresponse, dbus_wresponse, dbus_rdata,
           bus_timeout};
    n_tests++;
    if (((got ^ exp) & mask) != '0) begin
      n_fail++;
      $display("FAIL %s[%0d]: outputs %h, required %h (care mask %h)",
               tag, idx, got & mask, exp & mask, mask);
    end
  endtask

  task automatic run_row(input string tag, input int idx, input vec_t v);
    logic [137:0] exp, mask;
    ibus_rrequest = v.ir;  ibus_address = v.ia;
    dbus_rrequest = v.dr;  dbus_wrequest = v.dw;
    dbus_address  = v.da;  dbus_wdata    = v.dwd; dbus_wstrobe = v.ds;
    mem_rresponse = v.mrr; mem_wresponse = v.mwr; mem_rdata    = v.md;
    exp  = {v.er, v.ew, v.ea, v.ewd, v.es,
            v.eir, (v.eir ? v.erd : 32'h0), v.edr, v.edw, (v.edr ? v.erd : 32'h0),
            v.et};
    mask = {1'b1, 1'b1, {32{v.er | v.ew}}, {32{v.ew}}, {4{v.ew}},
            1'b1, {32{v.eir}}, 1'b1, 1'b1, {32{v.edr}}, 1'b1};
    @(negedge clock);
    check(tag, idx, exp, mask);
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with live requests/responses: every output must stay at zero.
    reset_n = 1'b0;
    idle_inputs();
    ibus_rrequest = 1'b1; ibus_address = 32'h100;
    dbus_wrequest = 1'b1; dbus_wdata = 32'hFFFF_FFFF; dbus_wstrobe = 4'hF;
    mem_rresponse = 1'b1; mem_wresponse = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #12;
    check("reset", 0, '0, '1);
    idle_inputs();
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // ibus read, response two cycles after issue
    tbl.push_back(mk(1,'h100, 0,0,0,0,0, 0,0,0, 1,0,'h100,0,0, 0,0,0,0,0));
    tbl.push_back(idle_row());
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'hDEADBEEF, 0,0,0,0,0, 1,0,0,'hDEADBEEF,0));
    tbl.push_back(idle_row());
    // simultaneous reads: dbus first, ibus the cycle after the dbus response
    tbl.push_back(mk(1,'h200, 1,0,'h300,0,0, 0,0,0, 1,0,'h300,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'hCAFEF00D, 0,0,0,0,0, 0,1,0,'hCAFEF00D,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0, 1,0,'h200,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h11112222, 0,0,0,0,0, 1,0,0,'h11112222,0));
    tbl.push_back(idle_row());
    // dbus write; a read response while a write is owned is ignored
    tbl.push_back(mk(0,0, 0,1,'h2000,'h12345678,'h3, 0,0,0, 0,1,'h2000,'h12345678,'h3, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h77, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 0,1,0, 0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(idle_row());
    // rrequest+wrequest together is a write
    tbl.push_back(mk(0,0, 1,1,'h44,'hA5A5A5A5,'hF, 0,0,0, 0,1,'h44,'hA5A5A5A5,'hF, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 0,1,0, 0,0,0,0,0, 0,0,1,0,0));
    // responses in IDLE are ignored
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,1,'h5, 0,0,0,0,0, 0,0,0,0,0));
    // dbus arrives while ibus busy: pends, issues the cycle after the response
    tbl.push_back(mk(1,'h500, 0,0,0,0,0, 0,0,0, 1,0,'h500,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 1,0,'h600,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h55, 0,0,0,0,0, 1,0,0,'h55,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0, 1,0,'h600,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h66, 0,0,0,0,0, 0,1,0,'h66,0));
    tbl.push_back(idle_row());
    // timeout in the 4th BUSY cycle with rdata 0, late response dropped
    tbl.push_back(mk(0,0, 1,0,'h700,0,0, 0,0,0, 1,0,'h700,0,0, 0,0,0,0,0));
    tbl.push_back(wait_row('hFFFFFFFF));
    tbl.push_back(wait_row('hFFFFFFFF));
    tbl.push_back(wait_row('hFFFFFFFF));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,'hFFFFFFFF, 0,0,0,0,0, 0,1,0,0,1));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'hBAD, 0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,'h800, 0,0,0,0,0, 0,0,0, 1,0,'h800,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h88, 0,0,0,0,0, 1,0,0,'h88,0));

    for (int i = 0; i < tbl.size(); i++) run_row("vec", i, tbl[i]);

    // Asynchronous reset while BUSY_I, then a stale response after release.
    run_row("rst", 0, mk(1,'h900, 0,0,0,0,0, 0,0,0, 1,0,'h900,0,0, 0,0,0,0,0));
    idle_inputs();
    #1;
    reset_n = 1'b0;
    mem_rresponse = 1'b1;
    mem_rdata = 32'h9999_9999;
    #1;
    check("rst", 1, '0, '1);
    @(negedge clock);
    mem_rresponse = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_row("rst", 2, mk(0,0, 0,0,0,0,0, 1,0,'h99, 0,0,0,0,0, 0,0,0,0,0));
    run_row("rst", 3, mk(1,'hA00, 0,0,0,0,0, 0,0,0, 1,0,'hA00,0,0, 0,0,0,0,0));
    run_row("rst", 4, mk(0,0, 0,0,0,0,0, 1,0,'hA0A0, 0,0,0,0,0, 1,0,0,'hA0A0,0));

`ifdef RVX_ARB_ROUND_ROBIN_EN
    // Three contested grants alternate dbus, ibus, dbus.
    rr_tbl.push_back(mk(1,'hA0, 1,0,'hB0,0,0, 0,0,0, 1,0,'hB0,0,0, 0,0,0,0,0));
    rr_tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h1, 0,0,0,0,0, 0,1,0,'h1,0));
    rr_tbl.push_back(mk(0,0, 1,0,'hB4,0,0, 0,0,0, 1,0,'hA0,0,0, 0,0,0,0,0));
    rr_tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h2, 0,0,0,0,0, 1,0,0,'h2,0));
    rr_tbl.push_back(mk(1,'hA4, 0,0,0,0,0, 0,0,0, 1,0,'hB4,0,0, 0,0,0,0,0));
    rr_tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h3, 0,0,0,0,0, 0,1,0,'h3,0));
    rr_tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0,0, 1,0,'hA4,0,0, 0,0,0,0,0));
    rr_tbl.push_back(mk(0,0, 0,0,0,0,0, 1,0,'h4, 0,0,0,0,0, 1,0,0,'h4,0));
    for (int i = 0; i < rr_tbl.size(); i++) run_row("rr", i, rr_tbl[i]);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
